// File: rtl/gshare_predictor_pkg.sv
// Shared types and constants for the gshare branch predictor.
package gshare_predictor_pkg;

  // Default table geometry; the top level takes these as parameter defaults.
  localparam int XLEN_DEF    = 32;
  localparam int PHT_IDX_DEF = 8;
  localparam int GHR_LEN_DEF = 8;
  localparam int BTB_IDX_DEF = 6;
  localparam int BTB_TAG_DEF = 10;

  // 2-bit direction counter encodings; the MSB is the taken prediction.
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // One BTB row in the default geometry.
  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]    target;
  } btb_entry_t;

endpackage

// File: rtl/gshare_predictor_sat_counter2.sv
// 2-bit saturating up/down counter update, used on the PHT write path.
module sat_counter2
  import gshare_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);

  // Step toward the requested direction, holding at either end of the range.
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != STRONG_T) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != STRONG_NT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor with tagged BTB and speculative global history.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int PHT_IDX = PHT_IDX_DEF,
  parameter int GHR_LEN = GHR_LEN_DEF,
  parameter int BTB_IDX = BTB_IDX_DEF,
  parameter int BTB_TAG = BTB_TAG_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic               lookup_is_branch,
  input  logic [XLEN-1:0]    lookup_pc,
  output logic               pred_taken,
  output logic [XLEN-1:0]    pred_target,
  output logic [GHR_LEN-1:0] pred_ghr,
  input  logic               upd_valid,
  input  logic [XLEN-1:0]    upd_pc,
  input  logic               upd_taken,
  input  logic [XLEN-1:0]    upd_target,
  input  logic [GHR_LEN-1:0] upd_ghr,
  input  logic               upd_mispredict,
  output logic [15:0]        perf_mispredicts
);

  localparam int PHT_N = 1 << PHT_IDX;
  localparam int BTB_N = 1 << BTB_IDX;

  // BTB row sized to this instance's tag and address widths.
  typedef struct packed {
    logic               valid;
    logic [BTB_TAG-1:0] tag;
    logic [XLEN-1:0]    target;
  } btb_row_t;

  logic [1:0]         pht_q [PHT_N];
  btb_row_t           btb_q [BTB_N];
  logic [GHR_LEN-1:0] ghr_q, ghr_d;
  logic [15:0]        perf_q, perf_d;

  logic [PHT_IDX-1:0] lkPhtIdx, updPhtIdx;
  logic [BTB_IDX-1:0] lkBtbIdx, updBtbIdx;
  logic [BTB_TAG-1:0] lkTag, updTag;
  logic [1:0]         lkCnt, updCntNew;
  logic               lkHit;
  logic               unusedUpdPc;

  // Only the index and tag slices of the resolved PC matter.
  assign unusedUpdPc = ^upd_pc;

  // History-hashed PHT indices; lookups use the live GHR, updates the GHR
  // that was captured with the branch.
  assign lkPhtIdx  = lookup_pc[PHT_IDX+1:2] ^ PHT_IDX'(ghr_q);
  assign updPhtIdx = upd_pc[PHT_IDX+1:2] ^ PHT_IDX'(upd_ghr);

  assign lkBtbIdx  = lookup_pc[BTB_IDX+1:2];
  assign lkTag     = lookup_pc[BTB_IDX+BTB_TAG+1:BTB_IDX+2];
  assign updBtbIdx = upd_pc[BTB_IDX+1:2];
  assign updTag    = upd_pc[BTB_IDX+BTB_TAG+1:BTB_IDX+2];

  assign lkCnt = pht_q[lkPhtIdx];
  assign lkHit = btb_q[lkBtbIdx].valid && (btb_q[lkBtbIdx].tag == lkTag);

  // Zero-latency prediction; a taken guess needs both direction and target.
  assign pred_taken       = lkCnt[1] && lkHit && lookup_is_branch;
  assign pred_target      = pred_taken ? btb_q[lkBtbIdx].target : lookup_pc + XLEN'(4);
  assign pred_ghr         = ghr_q;
  assign perf_mispredicts = perf_q;

  sat_counter2 u_updCounter (
    .cnt_i (pht_q[updPhtIdx]),
    .inc_i (upd_taken),
    .cnt_o (updCntNew)
  );

  // Next GHR: mispredict recovery wins and drops any same-cycle speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_mispredict) begin
      ghr_d = GHR_LEN'({upd_ghr, upd_taken});
    end else if (lookup_valid && lookup_is_branch) begin
      ghr_d = GHR_LEN'({ghr_q, pred_taken});
    end
  end

  // Mispredict counter holds at all-ones instead of wrapping.
  always_comb begin
    perf_d = perf_q;
    if (upd_valid && upd_mispredict && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  // GHR and performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q  <= '0;
      perf_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      perf_q <= perf_d;
    end
  end

  // PHT: every retired branch trains its counter toward the actual direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= WEAK_NT;
    end else if (upd_valid) begin
      pht_q[updPhtIdx] <= updCntNew;
    end
  end

  // BTB: taken branches allocate or overwrite their row; not-taken leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
    end else if (upd_valid && upd_taken) begin
      btb_q[updBtbIdx] <= '{valid: 1'b1, tag: updTag, target: upd_target};
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus random traffic
// compared against a table-level reference model.
module tb_gshare_predictor;

  localparam int XLEN = 32, PHT_IDX = 8, GHR_LEN = 8, BTB_IDX = 6, BTB_TAG = 10;
  localparam int PHT_N = 1 << PHT_IDX, BTB_N = 1 << BTB_IDX;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid, lookup_is_branch;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghr;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [7:0]  upd_ghr;
  logic [15:0] perf_mispredicts;

  gshare_predictor #(.XLEN(XLEN), .PHT_IDX(PHT_IDX), .GHR_LEN(GHR_LEN),
                     .BTB_IDX(BTB_IDX), .BTB_TAG(BTB_TAG)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_is_branch(lookup_is_branch), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: plain arrays of counters and BTB fields.
  int          mPht[PHT_N];
  bit          mValid[BTB_N];
  int          mTag[BTB_N];
  logic [31:0] mTarget[BTB_N];
  int          mGhr;
  int          mPerf;

  function automatic int phtOf(logic [31:0] pc, int g);
    return int'((pc / 4) % PHT_N) ^ (g % 256);
  endfunction

  function automatic int btbOf(logic [31:0] pc);
    return int'((pc / 4) % BTB_N);
  endfunction

  function automatic int tagOf(logic [31:0] pc);
    return int'((pc / (4 * BTB_N)) % (1 << BTB_TAG));
  endfunction

  function automatic bit mTaken(logic [31:0] pc, bit isBr);
    int b;
    b = btbOf(pc);
    return isBr && (mPht[phtOf(pc, mGhr)] >= 2) && mValid[b] && (mTag[b] == tagOf(pc));
  endfunction

  function automatic logic [31:0] mNext(logic [31:0] pc, bit isBr);
    if (mTaken(pc, isBr)) return mTarget[btbOf(pc)];
    return pc + 32'd4;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < PHT_N; i++) mPht[i] = 1;
    for (int i = 0; i < BTB_N; i++) begin
      mValid[i] = 1'b0; mTag[i] = 0; mTarget[i] = '0;
    end
    mGhr = 0;
    mPerf = 0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void modelClock();
    bit pt;
    int i, b;
    if (reset) begin
      modelReset();
      return;
    end
    pt = mTaken(lookup_pc, lookup_is_branch);
    if (upd_valid) begin
      i = phtOf(upd_pc, int'(upd_ghr));
      if (upd_taken) mPht[i] = (mPht[i] == 3) ? 3 : mPht[i] + 1;
      else           mPht[i] = (mPht[i] == 0) ? 0 : mPht[i] - 1;
      if (upd_taken) begin
        b = btbOf(upd_pc);
        mValid[b] = 1'b1; mTag[b] = tagOf(upd_pc); mTarget[b] = upd_target;
      end
    end
    if (upd_valid && upd_mispredict) begin
      if (mPerf < 65535) mPerf++;
      mGhr = (int'(upd_ghr) * 2 + int'(upd_taken)) % 256;
    end else if (lookup_valid && lookup_is_branch) begin
      mGhr = (mGhr * 2 + int'(pt)) % 256;
    end
  endfunction

  task automatic applyStimulus(input bit lv, input bit lb, input logic [31:0] lpc,
                               input bit uv, input logic [31:0] upc, input bit ut,
                               input logic [31:0] utgt, input logic [7:0] ug, input bit um);
    lookup_valid = lv; lookup_is_branch = lb; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_ghr = ug; upd_mispredict = um;
    #1;
  endtask

  task automatic tick();
    modelClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 8'h00, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target, pred_ghr} !== {1'b0, 32'h104, 8'h00}) begin
      bad++;
      $display("[TB] FAIL reset_pred: got taken=%0b target=%h ghr=%h, want 0 00000104 00",
               pred_taken, pred_target, pred_ghr);
    end
    total++;
    if (perf_mispredicts !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_perf: got %h want 0000", perf_mispredicts);
    end
  endtask

  task automatic test_train();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 32'h0, 1, 32'h100, 1, 32'h200, 8'h00, 0);
      tick();
    end
    applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h200}) begin
      bad++;
      $display("[TB] FAIL train_taken: got %0b %h want 1 00000200", pred_taken, pred_target);
    end
    applyStimulus(0, 0, 32'h0, 1, 32'h100, 0, 32'h0, 8'h00, 0);
    tick();
    applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h200}) begin
      bad++;
      $display("[TB] FAIL train_one_nt: got %0b %h want 1 00000200", pred_taken, pred_target);
    end
    applyStimulus(0, 0, 32'h0, 1, 32'h100, 0, 32'h0, 8'h00, 0);
    tick();
    applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL train_two_nt: got %0b %h want 0 00000104", pred_taken, pred_target);
    end
  endtask

  task automatic test_alias();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 32'h0, 1, 32'h100, 1, 32'h200, 8'h00, 0);
      tick();
    end
    // Saturate the PHT entry the alias PC will read, through a different BTB row.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 32'h0, 1, 32'h104, 1, 32'h300, 8'hC1, 0);
      tick();
    end
    applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h200}) begin
      bad++;
      $display("[TB] FAIL alias_owner: got %0b %h want 1 00000200", pred_taken, pred_target);
    end
    applyStimulus(0, 1, 32'h200, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h204}) begin
      bad++;
      $display("[TB] FAIL alias_tag_miss: got %0b %h want 0 00000204", pred_taken, pred_target);
    end
  endtask

  task automatic test_ghr();
    bit expPat[4];
    expPat = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 32'h0, 1, 32'h100, 1, 32'h200, 8'h02, 0);
      tick();
      applyStimulus(0, 0, 32'h0, 1, 32'h100, 1, 32'h200, 8'h05, 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
      total++;
      if (pred_taken !== expPat[k]) begin
        bad++;
        $display("[TB] FAIL ghr_spec_pred%0d: got %0b want %0b", k, pred_taken, expPat[k]);
      end
      tick();
    end
    idle();
    total++;
    if (pred_ghr !== 8'h0B) begin
      bad++;
      $display("[TB] FAIL ghr_spec: got %h want 0b", pred_ghr);
    end
    applyStimulus(1, 1, 32'h100, 1, 32'h180, 1, 32'h400, 8'h05, 1);
    tick();
    idle();
    total++;
    if (pred_ghr !== 8'h0B) begin
      bad++;
      $display("[TB] FAIL ghr_recover: got %h want 0b", pred_ghr);
    end
    total++;
    if (perf_mispredicts !== 16'd1) begin
      bad++;
      $display("[TB] FAIL ghr_recover_perf: got %h want 0001", perf_mispredicts);
    end
  endtask

  task automatic test_same_cycle();
    applyStimulus(0, 1, 32'h100, 1, 32'h100, 1, 32'h200, 8'h0B, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL same_cycle_old: got %0b %h want 0 00000104", pred_taken, pred_target);
    end
    tick();
    applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h200}) begin
      bad++;
      $display("[TB] FAIL same_cycle_new: got %0b %h want 1 00000200", pred_taken, pred_target);
    end
  endtask

  task automatic test_random();
    logic [31:0] lpc, upc;
    bit expT;
    logic [31:0] expN;
    for (int n = 0; n < 400; n++) begin
      lpc = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'(256 * $urandom_range(0, 1));
      upc = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'(256 * $urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, lpc,
                    1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                    $urandom & 32'hFFFF_FFFC, 8'($urandom), $urandom_range(0, 3) == 0);
      expT = mTaken(lookup_pc, lookup_is_branch);
      expN = mNext(lookup_pc, lookup_is_branch);
      total++;
      if ({pred_taken, pred_target} !== {expT, expN}) begin
        bad++;
        $display("[TB] FAIL rand_pred[%0d]: pc=%h got %0b %h want %0b %h",
                 n, lookup_pc, pred_taken, pred_target, expT, expN);
      end
      total++;
      if ({pred_ghr, perf_mispredicts} !== {8'(mGhr), 16'(mPerf)}) begin
        bad++;
        $display("[TB] FAIL rand_state[%0d]: got ghr=%h perf=%0d want ghr=%h perf=%0d",
                 n, pred_ghr, perf_mispredicts, 8'(mGhr), mPerf);
      end
      tick();
    end
  endtask

  task automatic test_perf_saturate();
    applyStimulus(0, 0, 32'h0, 1, 32'h100, 0, 32'h0, 8'h00, 1);
    for (int n = 0; n < 70000; n++) tick();
    idle();
    total++;
    if (perf_mispredicts !== 16'hFFFF) begin
      bad++;
      $display("[TB] FAIL perf_saturate: got %h want ffff", perf_mispredicts);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 1, 32'h100, 1, 32'h100, 1, 32'h200, 8'h05, 1);
    tick();
    reset = 1'b1;
    applyStimulus(1, 1, 32'h100, 1, 32'h100, 1, 32'h200, 8'h05, 1);
    tick();
    reset = 1'b0;
    applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target, pred_ghr, perf_mispredicts} !== {1'b0, 32'h104, 8'h00, 16'h0}) begin
      bad++;
      $display("[TB] FAIL reset_mid_state: got %0b %h ghr=%h perf=%h want 0 00000104 00 0000",
               pred_taken, pred_target, pred_ghr, perf_mispredicts);
    end
    // Saturate 0x100's PHT entry via another BTB row: the old 0x100 BTB row must be gone.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 32'h0, 1, 32'h104, 1, 32'h300, 8'h01, 0);
      tick();
    end
    applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL reset_mid_btb: got %0b %h want 0 00000104", pred_taken, pred_target);
    end
    // A single taken update from the reset counter value reaches the taken threshold.
    applyStimulus(0, 0, 32'h0, 1, 32'h180, 1, 32'h500, 8'h00, 0);
    tick();
    applyStimulus(0, 1, 32'h180, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    total++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h500}) begin
      bad++;
      $display("[TB] FAIL reset_mid_pht: got %0b %h want 1 00000500", pred_taken, pred_target);
    end
  endtask

  initial begin
    reset = 1'b1;
    modelReset();
    idle();
    @(negedge clk);
    test_reset();
    test_train();
    test_alias();
    test_ghr();
    test_same_cycle();
    test_random();
    test_perf_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare direction predictor with a tagged, valid-bit branch target buffer (BTB) and a speculative global history register (GHR) with mispredict recovery. It sits in fetch: decode marks branch lookups, and the ROB returns resolved outcomes at retire. It replaces the PC-indexed bimodal predictor with history-hashed indexing, partial-tag BTB hits and configurable table sizes.

## Interface
- XLEN, 32, address/data width
- PHT_IDX, 8, log2 of pattern history table entries (2-bit counters)
- GHR_LEN, 8, global history bits; must be ≤ PHT_IDX
- BTB_IDX, 6, log2 of BTB entries
- BTB_TAG, 10, partial tag bits stored per BTB entry
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lookup_valid  in  1  fetch lookup this cycle
- lookup_is_branch  in  1  looked-up instruction is a conditional branch (from predecode)
- lookup_pc  in  XLEN  PC to predict
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- pred_ghr  out  GHR_LEN  GHR value used for this prediction; travels with the branch to the ROB
- upd_valid  in  1  resolved branch from ROB
- upd_pc  in  XLEN  resolved branch PC
- upd_taken  in  1  actual direction
- upd_target  in  XLEN  actual taken target
- upd_ghr  in  GHR_LEN  pred_ghr captured at prediction time
- upd_mispredict  in  1  direction or target was mispredicted
- perf_mispredicts  out  16  saturating mispredict count

## Operation
- PHT index at lookup: lookup_pc[PHT_IDX+1:2] XOR zero-extended ghr. At update: upd_pc[PHT_IDX+1:2] XOR zero-extended upd_ghr.
- BTB index: pc[BTB_IDX+1:2]. Tag: pc[BTB_IDX+BTB_TAG+1:BTB_IDX+2]. A hit requires valid and a tag match.
- pred_taken = counter≥2 AND btb_hit AND lookup_is_branch.
- pred_target = btb target if pred_taken, else lookup_pc+4 (modulo 2^XLEN).
- pred_ghr = current ghr. All predictor outputs are combinational and independent of lookup_valid.
- Speculative GHR: on lookup_valid && lookup_is_branch, ghr <= {ghr[GHR_LEN-2:0], pred_taken}.
- Recovery: on upd_valid && upd_mispredict, ghr <= {upd_ghr[GHR_LEN-2:0], upd_taken}. Recovery has priority over a same-cycle speculative shift; that lookup's shift is dropped.
- PHT update on upd_valid: saturating increment if upd_taken, saturating decrement otherwise (bounded 0..3).
- BTB update on upd_valid && upd_taken: write valid=1, tag and target (allocate or overwrite). A not-taken update leaves the BTB unchanged.
- perf_mispredicts increments on upd_valid && upd_mispredict and saturates at 16'hFFFF.
- Reset values: all PHT counters 2'b01; all BTB valid bits 0; ghr 0; perf_mispredicts 0.
- With tables in reset state, outputs are pred_taken=0, pred_target=lookup_pc+4, pred_ghr=0.

## Timing
- Lookup has zero latency (combinational from lookup_pc and state).
- Updates are written at the posedge and are visible to lookups from the next cycle. There is no write-to-read bypass: a same-cycle lookup of the entry being updated sees the old value.
- Reset asserted mid-operation overrides every update and shift in that cycle.
- Inputs are sampled only when their valid is high. upd_* fields are don't-care while upd_valid=0.

## Structure
- The shared package holds these items:
  - the btb_entry_t typedef (valid, tag, target);
  - the counter constants (WEAK_NT=2'b01, STRONG_T=2'b11);
  - the parameter defaults.
- One sub-module, sat_counter2, is natural: a 2-bit saturating up/down update function/module reused for the PHT.
- The BTB and PHT are flop arrays in the top level.

## Test plan
- Reset, then lookup pc=0x100 branch → pred_taken=0, pred_target=0x104, pred_ghr=0.
- Three retired taken updates, pc=0x100, target=0x200, upd_ghr=0 → a lookup at 0x100 with ghr forced to 0 gives taken, target 0x200. One not-taken update → still taken (counter 2). A second not-taken update → not taken.
- BTB tag alias: train 0x100→0x200. Then look up 0x100+(1<<(BTB_IDX+2)) with a saturated counter → pred_taken=0 (tag miss).
- GHR speculation: four branch lookups predicted T,N,T,T → ghr=4'b1011 (low bits). A mispredict with upd_ghr=8'h05, upd_taken=1 in the same cycle as a branch lookup → ghr=8'h0B next cycle.
- Same-cycle update and lookup to the same PHT entry → the lookup reflects the pre-update counter; the following cycle reflects the new value.
- 70000 mispredict updates → perf_mispredicts=16'hFFFF. Reset mid-stream → all state is back at reset values next cycle.
